// File: rtl/aes128_iter_ctrl_if.sv
// ----------------------------------------------------------------------------
// aes128_iter_ctrl_if
//   Bundles the plaintext input channel, ciphertext output channel and status
//   signals of the iterative AES-128 controller.
//   master : block source / ciphertext sink side (drives in_*, abort, out_ready)
//   slave  : the controller (drives in_ready, out_*, busy, round_idx)
// ----------------------------------------------------------------------------
interface aes128_iter_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;
    logic [3:0]   round_idx;

    modport master (
        output in_valid, in_text, in_key, abort, out_ready,
        input  in_ready, out_valid, out_text, busy, round_idx
    );

    modport slave (
        input  in_valid, in_text, in_key, abort, out_ready,
        output in_ready, out_valid, out_text, busy, round_idx
    );
endinterface

// File: rtl/aes128_iter_ctrl.sv
// ----------------------------------------------------------------------------
// aes128_iter_ctrl
//   Iterative AES-128 encryptor: one round datapath reused for 10 rounds with
//   on-the-fly key expansion. One block in flight; IDLE -> ROUND -> DONE.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : aes128_iter_ctrl_if.slave (in valid/ready/text/key, abort,
//              out valid/ready/text, busy, round_idx)
//   ROUND_CYCLES >= 1 clocks per round; extra cycles are pure stalls.
// ----------------------------------------------------------------------------
module aes128_iter_ctrl #(
    parameter int ROUND_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    aes128_iter_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int CW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(ROUND_CYCLES - 1);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Entry x sits (255 - x) bytes above bit 0; 255 - x == ~x for a byte.
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte (row r, column c) lives at index 4c+r, counted from the MSB.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        // SubWord(RotWord(w3)) ^ Rcon
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [1:0]    fsm_q, fsm_d;
    logic [127:0]  st_q, st_d;
    logic [127:0]  rk_q, rk_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [127:0]  rk_next;
    logic [127:0]  sr_out;

    assign rk_next = expand_key(rk_q, rcon(rnd_q));
    assign sr_out  = shift_rows(sub_bytes(st_q));

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no
        // path through the case below can leave one unassigned (no latches).
        fsm_d = fsm_q;
        st_d  = st_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        cyc_d = cyc_q;
        case (fsm_q)
            S_IDLE: begin
                // abort in IDLE suppresses an accompanying in_valid.
                if (bus.in_valid && !bus.abort) begin
                    fsm_d = S_ROUND;
                    st_d  = bus.in_text ^ bus.in_key;
                    rk_d  = bus.in_key;
                    rnd_d = 4'd1;
                    cyc_d = '0;
                end
            end
            S_ROUND: begin
                if (bus.abort) begin
                    fsm_d = S_IDLE;
                    st_d  = '0;
                    rk_d  = '0;
                    rnd_d = '0;
                    cyc_d = '0;
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    rk_d  = rk_next;
                    if (rnd_q == 4'd10) begin
                        st_d  = sr_out ^ rk_next;
                        fsm_d = S_DONE;
                    end else begin
                        st_d  = mix_columns(sr_out) ^ rk_next;
                        rnd_d = rnd_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_DONE: begin
                // abort takes priority over the output handshake.
                if (bus.abort || bus.out_ready) begin
                    fsm_d = S_IDLE;
                    st_d  = '0;
                    rk_d  = '0;
                    rnd_d = '0;
                    cyc_d = '0;
                end
            end
            default: begin
                fsm_d = S_IDLE;
                st_d  = '0;
                rk_d  = '0;
                rnd_d = '0;
                cyc_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            st_q  <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
            cyc_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_d;
            cyc_q <= cyc_d;
        end
    end

    assign bus.in_ready  = (fsm_q == S_IDLE);
    assign bus.out_valid = (fsm_q == S_DONE);
    assign bus.busy      = (fsm_q != S_IDLE);
    assign bus.round_idx = rnd_q;
    // Intermediate round state never leaves the block.
    assign bus.out_text  = (fsm_q == S_DONE) ? st_q : '0;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes128_iter_ctrl
//   Scoreboard bench for aes128_iter_ctrl. dut_a runs with ROUND_CYCLES=1,
//   dut_b with ROUND_CYCLES=3. Expected ciphertexts are FIPS-197 vectors,
//   pushed on accept and popped on the output handshake.
// ----------------------------------------------------------------------------
module tb_aes128_iter_ctrl;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes128_iter_ctrl_if a_if ();
    aes128_iter_ctrl_if b_if ();

    aes128_iter_ctrl #(.ROUND_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    aes128_iter_ctrl #(.ROUND_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    logic [127:0] sb_a[$];
    logic [127:0] sb_b[$];
    logic [127:0] exp_a, exp_b;
    int acc_cnt_a = 0, hs_cnt_a = 0, acc_cyc_a = 0, hs_cyc_a = 0, ov_rise_a = 0;
    int acc_cnt_b = 0, hs_cnt_b = 0, acc_cyc_b = 0, ov_rise_b = 0;
    logic prev_ov_a = 1'b0, prev_ov_b = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, update the scoreboards
    // 1 time unit after the rising edge.
    task automatic tick();
        logic acc_a, hs_a, ab_a, acc_b, hs_b, ab_b;
        logic [127:0] ot_a, ot_b;
        @(negedge clk);
        acc_a = rst_n && a_if.in_valid && a_if.in_ready && !a_if.abort;
        hs_a  = rst_n && a_if.out_valid && a_if.out_ready && !a_if.abort;
        ab_a  = rst_n && a_if.abort && a_if.busy;
        ot_a  = a_if.out_text;
        acc_b = rst_n && b_if.in_valid && b_if.in_ready && !b_if.abort;
        hs_b  = rst_n && b_if.out_valid && b_if.out_ready && !b_if.abort;
        ab_b  = rst_n && b_if.abort && b_if.busy;
        ot_b  = b_if.out_text;
        @(posedge clk);
        #1;
        cyc_n++;
        if (ab_a) sb_a.delete();
        if (ab_b) sb_b.delete();
        if (acc_a) begin sb_a.push_back(exp_a); acc_cyc_a = cyc_n; acc_cnt_a++; end
        if (acc_b) begin sb_b.push_back(exp_b); acc_cyc_b = cyc_n; acc_cnt_b++; end
        if (hs_a) begin
            hs_cnt_a++;
            hs_cyc_a = cyc_n;
            if (sb_a.size() == 0) check("a_sb_underflow", 128'(sb_a.size()), 128'd1);
            else                  check("a_ciphertext", ot_a, sb_a.pop_front());
        end
        if (hs_b) begin
            hs_cnt_b++;
            if (sb_b.size() == 0) check("b_sb_underflow", 128'(sb_b.size()), 128'd1);
            else                  check("b_ciphertext", ot_b, sb_b.pop_front());
        end
        if (a_if.out_valid && !prev_ov_a) ov_rise_a = cyc_n;
        if (b_if.out_valid && !prev_ov_b) ov_rise_b = cyc_n;
        prev_ov_a = a_if.out_valid;
        prev_ov_b = b_if.out_valid;
    endtask

    // Present a block on dut_a until it is accepted.
    task automatic send_a(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
        int a0;
        a0 = acc_cnt_a;
        a_if.in_valid = 1'b1;
        a_if.in_key   = k;
        a_if.in_text  = p;
        exp_a         = c;
        for (int i = 0; i < 100 && acc_cnt_a == a0; i++) tick();
        a_if.in_valid = 1'b0;
        check("a_accept_timeout", 128'(acc_cnt_a != a0), 128'd1);
    endtask

    // Wait for the output handshake of the in-flight block on dut_a.
    task automatic wait_done_a();
        int h0;
        h0 = hs_cnt_a;
        for (int i = 0; i < 200 && hs_cnt_a == h0; i++) tick();
        check("a_done_timeout", 128'(hs_cnt_a != h0), 128'd1);
        check("a_latency", 128'(ov_rise_a - acc_cyc_a), 128'd10);
        check("a_in_ready_after_hs", 128'(a_if.in_ready), 128'd1);
        check("a_out_valid_after_hs", 128'(a_if.out_valid), 128'd0);
        check("a_out_text_after_hs", a_if.out_text, 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, rc_cnt[16];
        logic seen_ov;
        a_if.in_valid = 1'b0; a_if.in_text = '0; a_if.in_key = '0;
        a_if.abort    = 1'b0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_text = '0; b_if.in_key = '0;
        b_if.abort    = 1'b0; b_if.out_ready = 1'b1;
        exp_a = '0; exp_b = '0;

        // Reset state
        #23;
        check("rst_out_valid", 128'(a_if.out_valid), 128'd0);
        check("rst_busy", 128'(a_if.busy), 128'd0);
        check("rst_round_idx", 128'(a_if.round_idx), 128'd0);
        check("rst_out_text", a_if.out_text, 128'd0);
        check("rst_in_ready", 128'(a_if.in_ready), 128'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: FIPS-197 C.1
        send_a(K1, P1, C1);
        check("t1_busy", 128'(a_if.busy), 128'd1);
        check("t1_round_idx_first", 128'(a_if.round_idx), 128'd1);
        wait_done_a();

        // 2: backpressure in DONE; in_valid must be ignored
        a_if.out_ready = 1'b0;
        send_a(K2, P2, C2);
        for (int i = 0; i < 40 && !a_if.out_valid; i++) tick();
        check("t2_out_valid", 128'(a_if.out_valid), 128'd1);
        check("t2_done_round_idx", 128'(a_if.round_idx), 128'd10);
        a0 = acc_cnt_a;
        a_if.in_valid = 1'b1; a_if.in_key = K1; a_if.in_text = P1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 128'(a_if.out_valid), 128'd1);
            check("t2_hold_text", a_if.out_text, C2);
            check("t2_in_ready_low", 128'(a_if.in_ready), 128'd0);
        end
        check("t2_no_accept", 128'(acc_cnt_a - a0), 128'd0);
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        wait_done_a();

        // 3: back-to-back with in_valid held high
        send_a(K1, P1, C1);
        a0 = acc_cnt_a;
        a_if.in_valid = 1'b1; a_if.in_key = K2; a_if.in_text = P2; exp_a = C2;
        for (int i = 0; i < 100 && acc_cnt_a == a0; i++) tick();
        a_if.in_valid = 1'b0;
        check("t3_second_accept", 128'(acc_cnt_a - a0), 128'd1);
        check("t3_accept_after_hs", 128'(acc_cyc_a - hs_cyc_a), 128'd1);
        wait_done_a();

        // 4: abort at round 5, then a clean block
        send_a(K2, P2, C2);
        for (int i = 0; i < 20 && a_if.round_idx != 4'd5; i++) tick();
        check("t4_reached_round5", 128'(a_if.round_idx), 128'd5);
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        check("t4_idle_in_ready", 128'(a_if.in_ready), 128'd1);
        check("t4_busy", 128'(a_if.busy), 128'd0);
        check("t4_round_idx", 128'(a_if.round_idx), 128'd0);
        check("t4_sb_flushed", 128'(sb_a.size()), 128'd0);
        seen_ov = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_ov = seen_ov | a_if.out_valid;
        end
        check("t4_no_out_valid", 128'(seen_ov), 128'd0);
        // abort in IDLE beats an accompanying in_valid
        a0 = acc_cnt_a;
        a_if.in_valid = 1'b1; a_if.abort = 1'b1;
        tick();
        a_if.in_valid = 1'b0; a_if.abort = 1'b0;
        check("t4_idle_abort_no_accept", 128'(acc_cnt_a - a0), 128'd0);
        check("t4_idle_abort_in_ready", 128'(a_if.in_ready), 128'd1);
        send_a(K1, P1, C1);
        wait_done_a();

        // 5: asynchronous reset mid-round
        send_a(K2, P2, C2);
        tick(); tick(); tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 128'(a_if.out_valid), 128'd0);
        check("t5_busy", 128'(a_if.busy), 128'd0);
        check("t5_round_idx", 128'(a_if.round_idx), 128'd0);
        check("t5_out_text", a_if.out_text, 128'd0);
        sb_a.delete();
        sb_b.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_a(K1, P1, C1);
        wait_done_a();

        // 6: ROUND_CYCLES=3 on dut_b
        for (int r = 0; r < 16; r++) rc_cnt[r] = 0;
        a0 = acc_cnt_b;
        b_if.in_valid = 1'b1; b_if.in_key = K1; b_if.in_text = P1; exp_b = C1;
        for (int i = 0; i < 100 && acc_cnt_b == a0; i++) tick();
        b_if.in_valid = 1'b0;
        check("t6_accept", 128'(acc_cnt_b - a0), 128'd1);
        rc_cnt[b_if.round_idx]++;
        for (int i = 0; i < 100 && !b_if.out_valid; i++) begin
            tick();
            if (!b_if.out_valid) rc_cnt[b_if.round_idx]++;
        end
        check("t6_latency", 128'(ov_rise_b - acc_cyc_b), 128'd30);
        for (int r = 1; r <= 10; r++)
            check($sformatf("t6_round%0d_clocks", r), 128'(rc_cnt[r]), 128'd3);
        a0 = hs_cnt_b;
        tick();
        check("t6_handshake", 128'(hs_cnt_b - a0), 128'd1);
        check("t6_in_ready_after_hs", 128'(b_if.in_ready), 128'd1);
        check("sb_a_drained", 128'(sb_a.size()), 128'd0);
        check("sb_b_drained", 128'(sb_b.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
